// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback (retire) stage.
package wb_pkg;

   localparam int NREGS_C  = 16;
   localparam int DATA_W_C = 64;
   localparam int REG_ID_W = $clog2(NREGS_C);
   localparam int REG_RAX  = 0;
   localparam int REG_RDX  = 2;

   // One buffered ALU result; imul uses both write slots (rax, rdx).
   typedef struct packed {
      logic                we0;
      logic [REG_ID_W-1:0] dst0;
      logic [DATA_W_C-1:0] val0;
      logic                we1;
      logic [REG_ID_W-1:0] dst1;
      logic [DATA_W_C-1:0] val1;
      logic                halt;
   } wb_entry_t;

   typedef enum logic [1:0] {
      IDLE,
      WR0,
      WR1,
      HALTED
   } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Result buffer: circular buffer of wb_entry_t with an extra wrap bit on
// each pointer to tell full from empty.
import wb_pkg::*;

module wb_fifo #(
   parameter int DEPTH = 2
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic                      push,
   input  wb_entry_t                 din,
   input  logic                      pop,
   output wb_entry_t                 dout,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    level
);

   localparam int AW = $clog2(DEPTH);

   wb_entry_t       mem [DEPTH];
   logic [AW:0]     wr_ptr;
   logic [AW:0]     rd_ptr;

   assign dout  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level = wr_ptr - rd_ptr;

   // Pointer update; contents need no reset since empty masks them.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage write.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/writeback_unit.sv
// Retire stage: buffers ALU results, commits them into the 16x64 register
// file through one write port, and raises a sticky halt on retq.
// Optional build macro WB_BYPASS_EN forwards the in-flight write to the
// read ports and the flat register view in the same cycle.
//
// state  | meaning
// IDLE   | buffer empty, nothing to commit
// WR0    | head present: primary write (or lone secondary write)
// WR1    | second write of a dual-destination result
// HALTED | retq retired; terminal until reset
import wb_pkg::*;

module writeback_unit #(
   parameter int NREGS      = NREGS_C,
   parameter int DATA_W     = DATA_W_C,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic                          in_we0,
   input  logic [$clog2(NREGS)-1:0]      in_dst0,
   input  logic [DATA_W-1:0]             in_val0,
   input  logic                          in_we1,
   input  logic [$clog2(NREGS)-1:0]      in_dst1,
   input  logic [DATA_W-1:0]             in_val1,
   input  logic                          in_halt,
   input  logic [$clog2(NREGS)-1:0]      rd_a_id,
   input  logic [$clog2(NREGS)-1:0]      rd_b_id,
   output logic [DATA_W-1:0]             rd_a_val,
   output logic [DATA_W-1:0]             rd_b_val,
   output logic [0:NREGS*DATA_W-1]       reg_file_out,
   output logic                          halted,
   output logic [31:0]                   retired_count
);

   localparam int ID_W  = $clog2(NREGS);
   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

   wb_state_t          state;
   wb_state_t          state_nx;
   wb_entry_t          in_entry;
   wb_entry_t          head;
   logic               fifo_full;
   logic               fifo_empty;
   logic [LVL_W-1:0]   fifo_level;
   logic               push;
   logic               pop;
   logic               more_after_pop;
   logic               wr_en;
   logic [ID_W-1:0]    wr_id;
   logic [DATA_W-1:0]  wr_val;
   logic [DATA_W-1:0]  regs [NREGS];

   // Held low in reset so nothing is accepted while the unit is clearing.
   assign in_ready = reset_n && !fifo_full && !halted && (state != HALTED);
   assign push     = in_valid && in_ready;

   assign in_entry = '{we0: in_we0, dst0: in_dst0, val0: in_val0,
                       we1: in_we1, dst1: in_dst1, val1: in_val1,
                       halt: in_halt};

   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (push),
      .din     (in_entry),
      .pop     (pop),
      .dout    (head),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   // The entry pushed this cycle counts, so a lone result streams at one per cycle.
   assign more_after_pop = (fifo_level > LVL_W'(1)) || push;

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   // Next state, register write port and pop.
   always_comb begin
      state_nx = state;
      wr_en    = 1'b0;
      wr_id    = head.dst0;
      wr_val   = head.val0;
      pop      = 1'b0;
      case (state)
         IDLE: begin
            if (push || !fifo_empty) state_nx = WR0;
         end
         WR0: begin
            if (fifo_empty) begin
               state_nx = push ? WR0 : IDLE;
            end else if (head.we0 && head.we1) begin
               wr_en    = 1'b1;
               state_nx = WR1;
            end else begin
               wr_en = head.we0 || head.we1;
               if (!head.we0) begin
                  wr_id  = head.dst1;
                  wr_val = head.val1;
               end
               pop = 1'b1;
            end
         end
         WR1: begin
            wr_en  = 1'b1;
            wr_id  = head.dst1;
            wr_val = head.val1;
            pop    = 1'b1;
         end
         HALTED: ;
         default: state_nx = IDLE;
      endcase
      if (pop) begin
         if (head.halt)          state_nx = HALTED;
         else if (more_after_pop) state_nx = WR0;
         else                     state_nx = IDLE;
      end
   end

   // Architectural register array.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[wr_id] <= wr_val;
      end
   end

   // Sticky halt and retire counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         halted        <= 1'b0;
         retired_count <= '0;
      end else if (pop) begin
         retired_count <= retired_count + 32'd1;
         if (head.halt) halted <= 1'b1;
      end
   end

`ifdef WB_BYPASS_EN
   // Operand reads, forwarding the write in progress.
   always_comb begin
      rd_a_val = (wr_en && (wr_id == rd_a_id)) ? wr_val : regs[rd_a_id];
      rd_b_val = (wr_en && (wr_id == rd_b_id)) ? wr_val : regs[rd_b_id];
   end

   // Flat register view, reg 0 at the MSB end, with the write forwarded.
   always_comb begin
      reg_file_out = '0;
      for (int i = 0; i < NREGS; i++) begin
         reg_file_out[i*DATA_W +: DATA_W] = (wr_en && (wr_id == ID_W'(i))) ? wr_val : regs[i];
      end
   end
`else
   // Operand reads straight from the array.
   always_comb begin
      rd_a_val = regs[rd_a_id];
      rd_b_val = regs[rd_b_id];
   end

   // Flat register view, reg 0 at the MSB end.
   always_comb begin
      reg_file_out = '0;
      for (int i = 0; i < NREGS; i++) reg_file_out[i*DATA_W +: DATA_W] = regs[i];
   end
`endif

endmodule
